// File: rtl/aes_mix_pkg.sv
// Shared types and GF(2^8) helpers for the AES column-mixing engine.
package aes_mix_pkg;

  typedef enum logic [1:0] {
    MIX_FWD = 2'b00,
    MIX_INV = 2'b01,
    MIX_BYP = 2'b10
  } mix_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int NUM_COLS  = 4;
  localparam int COL_W     = 32;
  localparam int BYTE_W    = 8;
  localparam int STATE_W   = NUM_COLS * COL_W;
  localparam int COL_IDX_W = 2;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mul2(input logic [BYTE_W-1:0] a);
    return xtime(a);
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mul3(input logic [BYTE_W-1:0] a);
    return xtime(a) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mul9(input logic [BYTE_W-1:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mulb(input logic [BYTE_W-1:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] gf_muld(input logic [BYTE_W-1:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mule(input logic [BYTE_W-1:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// Block handshake bundle: input block channel, result channel and busy flag.
interface mix_columns_engine_if;
  import aes_mix_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_mode;
  logic [STATE_W-1:0] in_state;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;
  logic               busy;

  modport master (
    output in_valid, in_mode, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_mode, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_column_word.sv
// One 32-bit column through MixColumns, InvMixColumns or bypass; byte 0 is the MSB.
module mix_column_word
  import aes_mix_pkg::*;
(
  input  logic [1:0]       i_mode,
  input  logic [COL_W-1:0] i_col,
  output logic [COL_W-1:0] o_col
);
  logic [0:NUM_COLS-1][BYTE_W-1:0] w_a;
  logic [0:NUM_COLS-1][BYTE_W-1:0] w_f;
  logic [0:NUM_COLS-1][BYTE_W-1:0] w_i;

  assign w_a = i_col;

  for (genvar b = 0; b < NUM_COLS; b++) begin : g_byte
    assign w_f[b] = gf_mul2(w_a[b]) ^ gf_mul3(w_a[(b+1)%4]) ^
                    w_a[(b+2)%4] ^ w_a[(b+3)%4];
    assign w_i[b] = gf_mule(w_a[b]) ^ gf_mulb(w_a[(b+1)%4]) ^
                    gf_muld(w_a[(b+2)%4]) ^ gf_mul9(w_a[(b+3)%4]);
  end

  // Both 1x encodings pass the column through untouched.
  always_comb begin
    o_col = i_col;
    case (i_mode)
      MIX_FWD: o_col = w_f;
      MIX_INV: o_col = w_i;
      default: o_col = i_col;
    endcase
  end
endmodule

// File: rtl/mix_columns_engine.sv
// Iterative AES column mixer: COLS_PER_CYCLE columns per clock, IDLE/RUN/DONE handshake FSM.
module mix_columns_engine
  import aes_mix_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic                 Clk,
  input logic                 Reset_n,
  mix_columns_engine_if.slave bus
);
  localparam int NCYC  = NUM_COLS / COLS_PER_CYCLE;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e                          r_state;
  state_e                          w_state_nxt;
  logic                            r_live;
  logic [0:NUM_COLS-1][COL_W-1:0]  r_work;
  logic [1:0]                      r_mode;
  logic [CNT_W-1:0]                r_cnt;
  logic                            w_in_ready;
  logic                            w_out_valid;
  logic                            w_busy;
  logic                            w_accept;

  logic [COLS_PER_CYCLE-1:0][COL_IDX_W-1:0] w_idx;
  logic [COLS_PER_CYCLE-1:0][COL_W-1:0]     w_col_in;
  logic [COLS_PER_CYCLE-1:0][COL_W-1:0]     w_col_out;

  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
    assign w_idx[i]    = COL_IDX_W'(int'(r_cnt) * COLS_PER_CYCLE + i);
    assign w_col_in[i] = r_work[w_idx[i]];
    mix_column_word u_word (
      .i_mode (r_mode),
      .i_col  (w_col_in[i]),
      .o_col  (w_col_out[i])
    );
  end

  // r_live keeps in_ready low while reset is asserted even though the FSM sits in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = r_live;
        if (bus.in_valid && r_live) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
        if (bus.out_ready) w_state_nxt = bus.in_valid ? ST_RUN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = bus.in_valid & w_in_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
      r_work  <= '0;
      r_mode  <= MIX_FWD;
      r_cnt   <= '0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_work <= bus.in_state;
        r_mode <= bus.in_mode;
        r_cnt  <= '0;
      end else if (r_state == ST_RUN) begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) r_work[w_idx[i]] <= w_col_out[i];
        if (r_cnt != CNT_LAST) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_state = r_work;
  assign bus.busy      = w_busy;
endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Iterative, mode-selectable AES column-mixing engine for the 128-bit AES datapath.
- Performs forward MixColumns, InvMixColumns, or bypass on a full 128-bit state.
- Processes COLS_PER_CYCLE columns per clock and uses valid/ready handshakes on both sides.
- Sits between the ShiftRows/AddRoundKey stages of the round controller. Bypass serves the final round, which has no MixColumns.

Parameters:
- COLS_PER_CYCLE, 1, number of 32-bit columns transformed per cycle. Legal values are 1, 2, 4; any other value is an elaboration error.
- NCYC, 4/COLS_PER_CYCLE (localparam), cycles per block.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_mode  in  2  00 forward, 01 inverse, 1x bypass.
- in_state  in  128  state. Column c = bits [127-32c -: 32]. Within a column, byte 0 = [31:24].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_state  out  128  transformed state.
- busy  out  1  high in RUN.

Behaviour:
- Reset (async, Reset_n=0): state goes to IDLE; in_ready=0 while Reset_n=0 and 1 in IDLE afterwards; out_valid=0, busy=0, out_state=0, column counter=0. Reset mid-operation discards the block, with no partial output.
- FSM states are IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, the engine latches in_state into the work register and in_mode into the mode register, clears the counter, and goes to RUN.
- RUN: in_ready=0, busy=1. Each cycle it replaces columns [cnt*COLS_PER_CYCLE +: COLS_PER_CYCLE] of the work register with their transform, then cnt += 1. When cnt==NCYC-1 the transform is applied and the state goes to DONE.
- DONE: out_valid=1 and out_state = work register, held stable until accepted.
  - On out_ready, if in_valid is also high, in_ready=1 in the same cycle and the new block is accepted directly into RUN (zero bubble).
  - Otherwise the state goes to IDLE.
- Bypass mode still traverses RUN for NCYC cycles, with the columns unchanged. Latency is mode-independent.
- Latency: accept edge at cycle 0; out_valid rises after NCYC more edges (4, 2 or 1 cycles). Throughput is one block per NCYC+1 cycles when back-to-back through DONE->RUN.
- in_mode and in_state are sampled only at acceptance. Changes at other times have no effect.
- out_valid never drops without out_ready. in_ready is combinational from state and out_ready only. There is no combinational path from in_valid to in_ready.
- Arithmetic in GF(2^8), reduction polynomial 0x11b.
  - xtime(a) = (a<<1) ^ (a[7] ? 0x1b : 0).
  - Forward: r0 = 2a0^3a1^a2^a3 and rotations.
  - Inverse: r0 = e·a0^b·a1^d·a2^9·a3 and rotations.
  - All byte-wide, with no carries.
- Counter width is clog2(NCYC), minimum 1. With COLS_PER_CYCLE=4, RUN lasts one cycle.

Decomposition:
- Package aes_mix_pkg holds:
  - mix_mode_e enum (MIX_FWD=2'b00, MIX_INV=2'b01, MIX_BYP=2'b10).
  - xtime and gf_mul2/3/9/b/d/e functions.
  - state_e FSM enum.
  - Column-slice helper constants.
- Sub-module mix_column_word: combinational, one 32-bit column in, mode in, 32-bit column out. It is instantiated COLS_PER_CYCLE times via generate. Each instance is muxed onto the slice selected by cnt.

Test Plan:
- Forward, COLS_PER_CYCLE=1: state db135345_f20a225c_01010101_c6c6c6c6 -> out 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid exactly 4 cycles after accept.
- Inverse, all three parameter values: 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> db135345_f20a225c_01010101_c6c6c6c6. Latency 4/2/1; also d5d5d7d6 -> d4d4d4d5 in column 0.
- Bypass: random state -> identical out_state after NCYC cycles. Forward-then-inverse of 1000 random states returns the original.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state/out_valid stable, in_ready=0. Then raise out_ready with in_valid=1 -> second block accepted that edge and result valid NCYC cycles later.
- Reset mid-RUN: assert Reset_n=0 asynchronously at cnt=1 -> out_valid=0, in_ready=0 immediately. After release, in_ready=1 and the next block (2d26314c column forward -> 4d7ebdf8) completes correctly.
- Mode/state change after acceptance (in_mode toggled during RUN) -> result follows the mode latched at acceptance.
